// File: rtl/latch_sched_pkg.sv
// rtl/latch_sched_pkg.sv - shared types and helpers for the latch bank scheduler
package latch_sched_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = 1; v < value; v = v * 2) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Every phase must last at least one cycle or D/En ordering around the latch breaks.
  function automatic bit cyc_params_ok(input int setup_cyc, input int strobe_cyc, input int hold_cyc);
    return (setup_cyc >= 1) && (strobe_cyc >= 1) && (hold_cyc >= 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at an external pointer
module rr_arbiter
  import latch_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int pos;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      pos = int'(ptr) + off;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_bank_scheduler.sv
// rtl/latch_bank_scheduler.sv - arbitrates writers onto a latch bank with setup/strobe/hold sequencing
module latch_bank_scheduler
  import latch_sched_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int DW         = 8,
  parameter int AW         = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*AW-1:0]   Addr,
  input  logic [NREQ*DW-1:0]   Data,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Ack,
  output logic                 Busy,
  output logic [DW-1:0]        Lat_D,
  output logic [(2**AW)-1:0]   Lat_En
);

  localparam int IW  = clog2(NREQ);
  localparam int CW  = clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;
  localparam int NEL = 2 ** AW;

  if (!cyc_params_ok(SETUP_CYC, STROBE_CYC, HOLD_CYC)) begin : g_cyc_check
    $error("latch_bank_scheduler: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
  end

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [AW-1:0]   addr_r;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NEL-1:0]  en_oh;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (Req),
    .ptr   (ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = Addr[i*AW +: AW];
        sel_data = Data[i*DW +: DW];
      end
    end
  end

  assign en_oh = NEL'(1) << addr_r;

  // Lat_D is written only on grant, so it stays stable across setup, strobe and hold.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      addr_r <= '0;
      cnt    <= '0;
      Gnt    <= '0;
      Ack    <= '0;
      Busy   <= 1'b0;
      Lat_D  <= '0;
      Lat_En <= '0;
    end else begin
      Ack <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            addr_r <= sel_addr;
            Lat_D  <= sel_data;
            Gnt    <= pick_oh;
            win    <= pick_idx;
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYC - 1)) begin
            cnt    <= '0;
            Lat_En <= en_oh;
            state  <= STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STROBE: begin
          if (cnt == CW'(STROBE_CYC - 1)) begin
            cnt    <= '0;
            Lat_En <= '0;
            state  <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == CW'(HOLD_CYC - 1)) begin
            cnt   <= '0;
            Ack   <= Gnt;
            Gnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          ptr   <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_scheduler.sv
// tb/tb_latch_bank_scheduler.sv - directed scoreboard bench for latch_bank_scheduler
module tb_latch_bank_scheduler;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int NEL  = 4;

  logic                Clk = 1'b0;
  logic                Reset;
  logic [NREQ-1:0]     Req, Req2;
  logic [NREQ*AW-1:0]  Addr, Addr2;
  logic [NREQ*DW-1:0]  Data, Data2;
  logic [NREQ-1:0]     Gnt, Ack, Gnt2, Ack2;
  logic                Busy, Busy2;
  logic [DW-1:0]       Lat_D, Lat_D2;
  logic [NEL-1:0]      Lat_En, Lat_En2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int            who;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  item_t sb[$];

  always #5 Clk = ~Clk;

  latch_bank_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .Data(Data),
    .Gnt(Gnt), .Ack(Ack), .Busy(Busy), .Lat_D(Lat_D), .Lat_En(Lat_En)
  );

  latch_bank_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW),
                         .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Req(Req2), .Addr(Addr2), .Data(Data2),
    .Gnt(Gnt2), .Ack(Ack2), .Busy(Busy2), .Lat_D(Lat_D2), .Lat_En(Lat_En2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic post_req(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d);
    item_t it;
    Addr[who*AW +: AW] = a;
    Data[who*DW +: DW] = d;
    Req[who] = 1'b1;
    it.who = who;
    it.addr = a;
    it.data = d;
    sb.push_back(it);
  endtask

  // Follows one default-timing transaction from the grant edge to the IDLE cycle after Ack.
  task automatic run_txn(input bit drop_in_strobe);
    item_t e;
    logic [NREQ-1:0] oh;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow observed=empty expected=item");
      return;
    end
    e  = sb.pop_front();
    oh = NREQ'(1) << e.who;

    tick();
    check("gnt_setup", Gnt, oh);
    check("busy_setup", Busy, 1);
    check("lat_d_grant", Lat_D, e.data);
    check("en_setup", Lat_En, 0);
    check("ack_setup", Ack, 0);
    Data[e.who*DW +: DW] = ~e.data;
    Addr[e.who*AW +: AW] = e.addr + 2'd1;

    tick();
    check("en_strobe", Lat_En, NEL'(1) << e.addr);
    check("gnt_strobe", Gnt, oh);
    check("lat_d_strobe", Lat_D, e.data);
    if (drop_in_strobe) Req[e.who] = 1'b0;

    tick();
    check("en_hold", Lat_En, 0);
    check("gnt_hold", Gnt, oh);
    check("lat_d_hold", Lat_D, e.data);
    check("ack_hold", Ack, 0);

    tick();
    check("ack_done", Ack, oh);
    check("gnt_done", Gnt, 0);
    check("en_done", Lat_En, 0);
    check("busy_done", Busy, 1);
    check("lat_d_done", Lat_D, e.data);
    Req[e.who] = 1'b0;

    tick();
    check("ack_idle", Ack, 0);
    check("busy_idle", Busy, 0);
    check("gnt_idle", Gnt, 0);
    check("lat_d_idle", Lat_D, e.data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t e2;
    int en_cnt, first_en, last_en, ack_k;
    logic [NREQ-1:0] ack_val;
    bit d_ok;

    Reset = 1'b1;
    Req = '0; Addr = '0; Data = '0;
    Req2 = '0; Addr2 = '0; Data2 = '0;
    tick();
    tick();
    check("rst_gnt", Gnt, 0);
    check("rst_ack", Ack, 0);
    check("rst_busy", Busy, 0);
    check("rst_lat_d", Lat_D, 0);
    check("rst_en", Lat_En, 0);
    check("rst_busy2", Busy2, 0);
    check("rst_en2", Lat_En2, 0);
    Reset = 1'b0;
    tick();

    // Single requester 1, element 2.
    post_req(1, 2'd2, 8'hA5);
    run_txn(1'b0);

    // All three contend; requester 0 re-requests after its Ack and must wait its turn.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    post_req(0, 2'd0, 8'h11);
    post_req(1, 2'd1, 8'h22);
    post_req(2, 2'd3, 8'h33);
    run_txn(1'b0);
    post_req(0, 2'd2, 8'h44);
    run_txn(1'b0);
    run_txn(1'b0);
    run_txn(1'b0);

    // Requester 2 drops Req during STROBE; the write still completes.
    post_req(2, 2'd1, 8'h3C);
    run_txn(1'b1);

    // Reset mid-STROBE aborts without Ack.
    Addr[1*AW +: AW] = 2'd1;
    Data[1*DW +: DW] = 8'h5A;
    Req[1] = 1'b1;
    tick();
    tick();
    check("abort_strobe_en", Lat_En, 4'b0010);
    Reset = 1'b1;
    tick();
    check("abort_en", Lat_En, 0);
    check("abort_gnt", Gnt, 0);
    check("abort_busy", Busy, 0);
    check("abort_ack", Ack, 0);
    Reset = 1'b0;
    Req = '0;
    tick();
    tick();
    check("abort_no_ack", Ack, 0);
    check("abort_idle_busy", Busy, 0);

    // Highest then lowest element with extreme data.
    post_req(0, 2'd3, 8'hFF);
    run_txn(1'b0);
    post_req(2, 2'd0, 8'h00);
    run_txn(1'b0);

    // Stretched phases on the second instance: setup 2, strobe 3, hold 2.
    Addr2[0 +: AW] = 2'd1;
    Data2[0 +: DW] = 8'hC3;
    Req2 = 3'b001;
    e2.who = 0; e2.addr = 2'd1; e2.data = 8'hC3;
    sb.push_back(e2);
    e2 = sb.pop_front();
    tick();
    check("d2_gnt", Gnt2, 3'b001);
    check("d2_lat_d_grant", Lat_D2, e2.data);
    Data2[0 +: DW] = 8'h00;
    en_cnt = 0; first_en = 0; last_en = 0; ack_k = 0; ack_val = '0; d_ok = 1'b1;
    for (int k = 2; k <= 20 && ack_k == 0; k++) begin
      tick();
      if (Lat_En2 !== '0) begin
        en_cnt++;
        if (first_en == 0) first_en = k;
        last_en = k;
        check("d2_en_onehot", Lat_En2, NEL'(1) << e2.addr);
      end
      if (Lat_D2 !== e2.data) d_ok = 1'b0;
      if (Ack2 !== '0) begin
        ack_k = k;
        ack_val = Ack2;
      end
    end
    check("d2_en_cycles", en_cnt, 3);
    check("d2_en_first", first_en, 3);
    check("d2_en_last", last_en, 5);
    check("d2_ack_cycle", ack_k, 8);
    check("d2_ack_val", ack_val, 3'b001);
    check("d2_lat_d_stable", d_ok, 1);
    Req2 = '0;
    tick();
    check("d2_idle_busy", Busy2, 0);
    check("d2_idle_ack", Ack2, 0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
